// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard for an in-order pipeline: detects RAW and
// mul/div structural hazards in D, raises stall/bubble, and counts stall cycles.
module hazard_scoreboard #(
   parameter int REG_AW  = 5,
   parameter int ALU_LAT = 1,
   parameter int LD_LAT  = 2,
   parameter int MD_LAT  = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ext_stall,
   input  logic              flush_in,
   input  logic              issue_valid,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   input  logic              rs_used,
   input  logic              rt_used,
   input  logic              branch_d,
   input  logic [REG_AW-1:0] dst,
   input  logic              dst_wen,
   input  logic [1:0]        dst_class,
   output logic              stall_d,
   output logic              flush_e,
   output logic              md_busy,
   output logic [31:0]       stall_cnt
);

   localparam int NREG    = 1 << REG_AW;
   localparam int MAX_AL  = (ALU_LAT > LD_LAT) ? ALU_LAT : LD_LAT;
   localparam int MAX_LAT = (MAX_AL > MD_LAT) ? MAX_AL : MD_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   localparam logic [1:0] CLS_LOAD   = 2'd1;
   localparam logic [1:0] CLS_MULDIV = 2'd2;

   logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0]           md_q, md_d;
   logic [31:0]             stall_cnt_q, stall_cnt_d;

   logic [CW-1:0] lat;
   logic          rs_haz, rt_haz, md_haz, haz, do_issue;

   // Branches resolve in D, so a result due at E next cycle is still too late.
   function automatic logic src_haz(input logic [CW-1:0] c, input logic used,
                                    input logic nz, input logic br);
      src_haz = used && nz && ((c > CW'(1)) || ((c != '0) && br));
   endfunction

   always_comb begin
      case (dst_class)
         CLS_LOAD:   lat = CW'(LD_LAT);
         CLS_MULDIV: lat = CW'(MD_LAT);
         default:    lat = CW'(ALU_LAT);
      endcase
   end

   assign md_busy  = (md_q > CW'(1));
   assign rs_haz   = src_haz(cnt_q[rs], rs_used, (rs != '0), branch_d);
   assign rt_haz   = src_haz(cnt_q[rt], rt_used, (rt != '0), branch_d);
   assign md_haz   = (dst_class == CLS_MULDIV) && md_busy;
   assign haz      = issue_valid && (rs_haz || rt_haz || md_haz);
   assign stall_d  = ext_stall || (haz && !flush_in);
   assign flush_e  = flush_in || (haz && !ext_stall);
   assign do_issue = issue_valid && !stall_d && !flush_in && !ext_stall;

   always_comb begin
      logic [CW-1:0] dec;
      cnt_d = cnt_q;
      for (int r = 1; r < NREG; r++) begin
         dec = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
         cnt_d[r] = dec;
         // WAW: keep whichever result lands later.
         if (do_issue && dst_wen && (dst == REG_AW'(r)))
            cnt_d[r] = (dec > lat) ? dec : lat;
         if (ext_stall)
            cnt_d[r] = cnt_q[r];
      end
      cnt_d[0] = '0;
   end

   always_comb begin
      md_d = md_q;
      if (!ext_stall) begin
         if (do_issue && (dst_class == CLS_MULDIV))
            md_d = CW'(MD_LAT);
         else if (md_q != '0)
            md_d = md_q - CW'(1);
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (haz && !flush_in && !ext_stall && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_q       <= '0;
         md_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         md_q        <= md_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, branch, mul/div, freeze,
// flush priority, WAW and reset scenarios with hand-computed expectations.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ext_stall, flush_in, issue_valid;
   logic [4:0]  rs, rt, dst;
   logic        rs_used, rt_used, branch_d, dst_wen;
   logic [1:0]  dst_class;
   logic        stall_d, flush_e, md_busy;
   logic [31:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n;

   hazard_scoreboard dut (
      .clk(clk), .resetn(resetn), .ext_stall(ext_stall), .flush_in(flush_in),
      .issue_valid(issue_valid), .rs(rs), .rt(rt), .rs_used(rs_used),
      .rt_used(rt_used), .branch_d(branch_d), .dst(dst), .dst_wen(dst_wen),
      .dst_class(dst_class), .stall_d(stall_d), .flush_e(flush_e),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] c, input logic [4:0] d,
                        input logic w, input logic [4:0] s, input logic su,
                        input logic [4:0] t, input logic tu, input logic b);
      issue_valid = v; dst_class = c; dst = d; dst_wen = w;
      rs = s; rs_used = su; rt = t; rt_used = tu; branch_d = b;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0; ext_stall = 1'b0; flush_in = 1'b0;
      idle();
      ticks(2);
      resetn = 1'b1;
      #1;
      chk("rst_stall", stall_d, 0);
      chk("rst_flush", flush_e, 0);
      chk("rst_md", md_busy, 0);
      chk("rst_scnt", stall_cnt, 0);
      ext_stall = 1'b1; #1;
      chk("rst_ext_stall", stall_d, 1);
      chk("rst_ext_flush", flush_e, 0);
      ext_stall = 1'b0; flush_in = 1'b1; #1;
      chk("rst_fl_stall", stall_d, 0);
      chk("rst_fl_flush", flush_e, 1);
      flush_in = 1'b0;

      // load-use
      drive(1, 1, 5, 1, 0, 0, 0, 0, 0); #1;
      chk("lu_issue", stall_d, 0);
      tick();
      drive(1, 0, 6, 1, 5, 0, 0, 0, 0); #1;
      chk("lu_unused", stall_d, 0);
      drive(1, 0, 6, 1, 5, 1, 0, 0, 0); #1;
      chk("lu_stall", stall_d, 1);
      chk("lu_flush", flush_e, 1);
      tick();
      chk("lu_go", stall_d, 0);
      chk("lu_scnt", stall_cnt, 1);
      tick(); idle(); ticks(3);

      // ALU -> branch
      drive(1, 0, 3, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 3, 1, 1); #1;
      chk("br_stall", stall_d, 1);
      tick();
      chk("br_go", stall_d, 0);
      tick(); idle(); ticks(2);
      chk("br_scnt", stall_cnt, 2);
      drive(1, 0, 3, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 3, 1, 0); #1;
      chk("nobr_stall", stall_d, 0);
      tick(); idle(); ticks(2);
      chk("nobr_scnt", stall_cnt, 2);

      // mul/div back to back (HI/LO target)
      drive(1, 2, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("md_first", stall_d, 0);
      tick();
      chk("md_busy", md_busy, 1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!stall_d) break;
         n++;
         tick();
      end
      chk("md_stalls", n, 31);
      chk("md_fall", md_busy, 0);
      chk("md_scnt", stall_cnt, 33);
      tick();
      chk("md_reload", md_busy, 1);
      idle();
      resetn = 1'b0; tick(); resetn = 1'b1; #1;
      chk("mid_rst_md", md_busy, 0);
      chk("mid_rst_scnt", stall_cnt, 0);
      drive(1, 2, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("mid_rst_issue", stall_d, 0);
      idle();

      // freeze while a load hazard is pending
      drive(1, 1, 5, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 6, 1, 5, 1, 0, 0, 0); ext_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("fz_stall", stall_d, 1);
         chk("fz_flush", flush_e, 0);
         tick();
      end
      ext_stall = 1'b0; #1;
      chk("fz_scnt", stall_cnt, 0);
      chk("fz_rel_stall", stall_d, 1);
      chk("fz_rel_flush", flush_e, 1);
      tick();
      chk("fz_go", stall_d, 0);
      chk("fz_scnt2", stall_cnt, 1);
      tick(); idle(); ticks(3);

      // flush beats a load-use stall; counter keeps draining
      drive(1, 1, 5, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 6, 1, 5, 1, 0, 0, 0); flush_in = 1'b1; #1;
      chk("fl_stall", stall_d, 0);
      chk("fl_flush", flush_e, 1);
      tick();
      flush_in = 1'b0; #1;
      chk("fl_dec", stall_d, 0);
      chk("fl_scnt", stall_cnt, 1);
      drive(1, 0, 6, 1, 5, 1, 0, 0, 1); #1;
      chk("fl_kept", stall_d, 1);
      idle(); ticks(3);

      // r0 is never tracked
      drive(1, 1, 0, 1, 0, 1, 0, 1, 1); tick();
      drive(1, 0, 0, 1, 0, 1, 0, 1, 1); #1;
      chk("r0_stall", stall_d, 0);
      tick(); idle(); ticks(2);

      // WAW LOAD r7 then ALU r7
      drive(1, 1, 7, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 7, 1, 0, 0, 0, 0, 0); #1;
      chk("waw_iss", stall_d, 0);
      tick();
      drive(1, 0, 0, 0, 7, 1, 0, 0, 1); #1;
      chk("waw_br", stall_d, 1);
      idle(); ticks(3);

      // WAW MULDIV r7 then ALU r7: the long latency must survive
      drive(1, 2, 7, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 7, 1, 0, 0, 0, 0, 0); #1;
      chk("wawmd_iss", stall_d, 0);
      tick();
      drive(1, 0, 8, 1, 7, 1, 0, 0, 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (!stall_d) break;
         n++;
         tick();
      end
      chk("wawmd_stalls", n, 30);
      tick(); idle(); ticks(2);

      // reserved class behaves as ALU
      drive(1, 3, 9, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 9, 1, 0, 0, 1); #1;
      chk("c3_stall", stall_d, 1);
      tick();
      chk("c3_go", stall_d, 0);
      tick(); idle(); tick();
      chk("final_scnt", stall_cnt, 32);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
